// File: rtl/mpadder_ctrl.sv
// mpadder_ctrl: sequencer for one Montgomery product C = A*B*2^-N mod M on
// the mpadder carry-save datapath. B is consumed LSB first. Each set bit
// costs an extra ADD_A cycle. Every bit costs one SHIFT cycle, in which the
// accumulator parity (cZero) picks whether M is added. After the loop the
// sum is resolved chunk by chunk. Then M is subtracted in full sweeps until
// the adder reports completion on carry.
//
// Ports
//   clk, resetn        clock, synchronous active-low reset
//   start, in_b        command; in_b latched when start is accepted in IDLE
//   cZero, carry       accumulator parity / subtract-finished strobe
//   enableC, shift     accumulator load / load shifted right by 1
//   subtract           adder in subtract mode (SUB only)
//   showFluffyPonies   chunk select, 4'd8 when idle or done
//   a_sel              in_a mux: 00 zero, 01 A, 10 M, 11 -M
//   busy, done, error  status; done/error are one-cycle pulses
module mpadder_ctrl #(
  parameter int N_BITS     = 512,
  parameter int CHUNKS     = 5,
  parameter int MAX_PASSES = 4
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  input  logic [N_BITS-1:0] in_b,
  input  logic              cZero,
  input  logic              carry,
  output logic              enableC,
  output logic              shift,
  output logic              subtract,
  output logic [3:0]        showFluffyPonies,
  output logic [1:0]        a_sel,
  output logic              busy,
  output logic              done,
  output logic              error
);
  localparam int BW = $clog2(N_BITS);
  localparam int PW = (MAX_PASSES > 1) ? $clog2(MAX_PASSES) : 1;

  typedef enum logic [2:0] {IDLE, ADD_A, SHIFT, RESOLVE, SUB, DONE} state_t;

  state_t            state_q, state_d;
  logic [N_BITS-1:0] b_q, b_d;
  logic [BW-1:0]     bit_q, bit_d;
  logic [PW-1:0]     pass_q, pass_d;
  logic [3:0]        chunk_q, chunk_d;
  logic              err_q, err_d;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= IDLE;
      b_q     <= '0;
      bit_q   <= '0;
      pass_q  <= '0;
      chunk_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      b_q     <= b_d;
      bit_q   <= bit_d;
      pass_q  <= pass_d;
      chunk_q <= chunk_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    b_d     = b_q;
    bit_d   = bit_q;
    pass_d  = pass_q;
    chunk_d = chunk_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: if (start) begin
        b_d     = in_b;
        bit_d   = '0;
        pass_d  = '0;
        chunk_d = '0;
        err_d   = 1'b0;
        state_d = in_b[0] ? ADD_A : SHIFT;
      end
      ADD_A: state_d = SHIFT;
      SHIFT: begin
        b_d = b_q >> 1;
        if (bit_q == BW'(N_BITS-1)) begin
          // Clear rather than increment so the counter never wraps.
          bit_d   = '0;
          chunk_d = '0;
          state_d = RESOLVE;
        end else begin
          bit_d   = bit_q + 1'b1;
          // b_q[1] is the bit that becomes current after this shift.
          state_d = b_q[1] ? ADD_A : SHIFT;
        end
      end
      RESOLVE: begin
        if (chunk_q == 4'(CHUNKS-1)) begin
          chunk_d = '0;
          state_d = SUB;
        end else begin
          chunk_d = chunk_q + 1'b1;
        end
      end
      SUB: begin
        // carry only means "finished" on the last chunk of a sweep.
        if (chunk_q == 4'(CHUNKS-1)) begin
          chunk_d = '0;
          if (carry) begin
            state_d = DONE;
          end else if (pass_q == PW'(MAX_PASSES-1)) begin
            err_d   = 1'b1;
            state_d = DONE;
          end else begin
            pass_d = pass_q + 1'b1;
          end
        end else begin
          chunk_d = chunk_q + 1'b1;
        end
      end
      DONE: begin
        chunk_d = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs decode state only; a_sel in SHIFT follows the live cZero.
  always_comb begin
    enableC          = (state_q == ADD_A);
    shift            = (state_q == SHIFT);
    subtract         = (state_q == SUB);
    busy             = (state_q != IDLE);
    done             = (state_q == DONE);
    error            = (state_q == DONE) && err_q;
    showFluffyPonies = (state_q == IDLE || state_q == DONE) ? 4'd8 : chunk_q;
    a_sel            = 2'b00;
    unique case (state_q)
      ADD_A:   a_sel = 2'b01;
      SHIFT:   a_sel = cZero ? 2'b10 : 2'b00;
      SUB:     a_sel = 2'b11;
      default: a_sel = 2'b00;
    endcase
  end
endmodule

// File: tb/tb_mpadder_ctrl.sv
module tb_mpadder_ctrl;
  localparam int NB = 512;
  localparam int CH = 5;
  localparam int MP = 4;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          start = 1'b0;
  logic [NB-1:0] in_b = '0;
  logic          cZero = 1'b0;
  logic          carry = 1'b0;
  logic          enableC, shift, subtract, busy, done, error;
  logic [3:0]    showFluffyPonies;
  logic [1:0]    a_sel;

  mpadder_ctrl #(.N_BITS(NB), .CHUNKS(CH), .MAX_PASSES(MP)) dut (
    .clk(clk), .resetn(resetn), .start(start), .in_b(in_b),
    .cZero(cZero), .carry(carry), .enableC(enableC), .shift(shift),
    .subtract(subtract), .showFluffyPonies(showFluffyPonies),
    .a_sel(a_sel), .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  typedef struct {
    int start_cyc;
    int lat;
    int err;
    int n_en;
    int n_sh;
    int n_sub;
  } exp_t;

  exp_t sb[$];
  int n_chk = 0, n_err = 0;
  int cyc = 0;
  int cz_mode = 0;
  int carry_on = 1;
  int en_c = 0, sh_c = 0, sub_c = 0, viol = 0, sweep = 0;

  task automatic chk(input string tag, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // Monitor: counts strobes, checks per-cycle rules, drives cZero/carry,
  // and pops the scoreboard when done is seen.
  always @(negedge clk) begin
    if (!resetn) begin
      en_c = 0; sh_c = 0; sub_c = 0; viol = 0; sweep = 0;
      carry = 1'b0;
    end else begin
      if (enableC) en_c++;
      if (shift) sh_c++;
      if (subtract) sub_c++;
      if (enableC && shift) viol++;
      if (shift && a_sel != (cZero ? 2'b10 : 2'b00)) viol++;
      if (enableC && a_sel != 2'b01) viol++;
      if (subtract && a_sel != 2'b11) viol++;
      if (busy && !done && showFluffyPonies >= CH) viol++;
      if (!busy && (showFluffyPonies != 4'd8 || enableC || shift || subtract || done)) viol++;
      if (done) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("latency", cyc - e.start_cyc + 1, e.lat);
          chk("error", int'(error), e.err);
          chk("enableC_cnt", en_c, e.n_en);
          chk("shift_cnt", sh_c, e.n_sh);
          chk("subtract_cnt", sub_c, e.n_sub);
          chk("rule_viol", viol, 0);
        end
        en_c = 0; sh_c = 0; sub_c = 0; viol = 0; sweep = 0;
      end
      if (subtract && showFluffyPonies == 4'(CH-1)) begin
        sweep++;
        carry = (sweep == carry_on);
      end else begin
        carry = 1'b0;
      end
      case (cz_mode)
        0: cZero = 1'b0;
        1: cZero = 1'b1;
        2: cZero = ~cZero;
        default: cZero = 1'($urandom);
      endcase
    end
  end

  function automatic logic [NB-1:0] rand_b();
    logic [NB-1:0] b;
    for (int i = 0; i < NB / 32; i++) b[i*32 +: 32] = $urandom;
    return b;
  endfunction

  task automatic push_start(input logic [NB-1:0] b);
    exp_t e;
    int pop, passes;
    pop = $countones(b);
    passes = (carry_on >= 1 && carry_on <= MP) ? carry_on : MP;
    e.start_cyc = cyc;
    e.lat   = 1 + NB + pop + CH + CH * passes + 1;
    e.err   = (carry_on >= 1 && carry_on <= MP) ? 0 : 1;
    e.n_en  = pop;
    e.n_sh  = NB;
    e.n_sub = CH * passes;
    in_b  = b;
    start = 1'b1;
    sb.push_back(e);
    @(negedge clk); #1;
    start = 1'b0;
  endtask

  // mid_start: pulse a second start during the loop.
  // start_in_done: hold start high during the DONE cycle.
  task automatic run(input logic [NB-1:0] b, input int czm, input int con,
                     input bit mid_start, input bit start_in_done);
    int t;
    cz_mode = czm;
    carry_on = con;
    @(negedge clk); #1;
    push_start(b);
    if (mid_start) begin
      repeat (100) @(negedge clk);
      #1;
      in_b = ~b;
      start = 1'b1;
      @(negedge clk); #1;
      start = 1'b0;
    end
    t = 0;
    while (!done && t < 4000) begin
      @(negedge clk); #1;
      t++;
    end
    chk("done_seen", int'(done), 1);
    if (start_in_done) start = 1'b1;
    @(negedge clk); #1;
    start = 1'b0;
    chk("busy_after_done", int'(busy), 0);
    @(negedge clk); #1;
    chk("idle_stays", int'(busy), 0);
  endtask

  initial begin
    logic [NB-1:0] ones, one;
    int t;
    ones = '1;
    one = '0;
    one[0] = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_show", int'(showFluffyPonies), 8);
    chk("rst_asel", int'(a_sel), 0);
    chk("rst_strobes", int'({enableC, shift, subtract, done, error}), 0);
    resetn = 1'b1;

    run('0, 0, 1, 1'b0, 1'b0);      // B=0: 524-cycle latency
    run(ones, 0, 1, 1'b0, 1'b0);    // all ones: 512 ADD_A/SHIFT pairs
    run(one, 1, 3, 1'b0, 1'b0);     // cZero=1, carry on 3rd sweep
    run(rand_b(), 2, 0, 1'b0, 1'b0); // toggling cZero, carry never: error
    run(rand_b(), 3, 2, 1'b1, 1'b1); // ignored starts mid-loop and in DONE

    // Reset during SUB chunk 2 discards the operation.
    cz_mode = 3;
    carry_on = 0;
    @(negedge clk); #1;
    push_start(rand_b());
    t = 0;
    while (!(subtract && showFluffyPonies == 4'd2) && t < 4000) begin
      @(negedge clk); #1;
      t++;
    end
    chk("reach_sub2", int'(subtract && showFluffyPonies == 4'd2), 1);
    resetn = 1'b0;
    sb.delete();
    @(negedge clk); #1;
    chk("rst_mid_show", int'(showFluffyPonies), 8);
    chk("rst_mid_busy", int'(busy), 0);
    chk("rst_mid_done", int'({done, error, subtract}), 0);
    resetn = 1'b1;
    @(negedge clk); #1;
    chk("rst_mid_after", int'({busy, done}), 0);

    run(rand_b(), 3, 1, 1'b0, 1'b0); // recovers cleanly after reset
    chk("sb_empty", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
